// File: rtl/mw_wb_stage_if.sv
// Bundle of the writeback-stage signals: pipeline control, the upstream
// instruction fields, and the register-file write port plus status outputs.
// The pipeline control and upstream fields drive the stage, and the stage
// drives the write port and status outputs.
interface mw_wb_stage_if;
  // Pipeline control
  logic        stall;
  logic        flush;

  // Upstream instruction fields
  logic        in_valid;
  logic [4:0]  in_opcode;
  logic [4:0]  in_aluop;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc_plus1;
  logic        in_overflow;

  // Register-file write port and architectural status
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] last_status;
  logic [7:0]  ovf_count;

  modport master (
    output stall, flush,
    output in_valid, in_opcode, in_aluop, in_rd,
    output in_alu_result, in_mem_data, in_pc_plus1, in_overflow,
    input  wb_en, wb_addr, wb_data, last_status, ovf_count
  );

  modport slave (
    input  stall, flush,
    input  in_valid, in_opcode, in_aluop, in_rd,
    input  in_alu_result, in_mem_data, in_pc_plus1, in_overflow,
    output wb_en, wb_addr, wb_data, last_status, ovf_count
  );
endinterface

// File: rtl/mw_wb_stage.sv
// Memory/writeback pipeline stage. One stage register holds the instruction
// leaving memory. The register-file write is decoded combinationally from that
// register, so an instruction captured at one edge writes back in the next
// cycle. Arithmetic overflow on add, sub or addi is turned into a write of a
// status code to r30 and is counted in a saturating counter.
module mw_wb_stage (
  input  logic         clock,
  input  logic         reset_n,
  mw_wb_stage_if.slave bus
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;

  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  // Overflow status codes written to r30 (zero means no exception).
  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_ADD  = 2'd1,
    ST_ADDI = 2'd2,
    ST_SUB  = 2'd3
  } status_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_plus1;
    logic        overflow;
  } stage_t;

  logic        r_valid;
  stage_t      r_stage;
  logic [31:0] r_last_status;
  logic [7:0]  r_ovf_count;

  stage_t      w_in;
  status_e     w_status;
  logic        w_is_exc;
  logic        w_writes;
  logic [4:0]  w_dest;
  logic [31:0] w_value;
  logic        w_commit;
  logic        w_wb_en;

  assign w_in = '{
    opcode:     bus.in_opcode,
    aluop:      bus.in_aluop,
    rd:         bus.in_rd,
    alu_result: bus.in_alu_result,
    mem_data:   bus.in_mem_data,
    pc_plus1:   bus.in_pc_plus1,
    overflow:   bus.in_overflow
  };

  // Stage register: reset first, then flush inserts a bubble, then stall holds the entry, otherwise the inputs are captured.
  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_stage <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_valid <= bus.in_valid;
      r_stage <= w_in;
    end
  end

  // Classify the overflow exception. The flag only matters for add, sub and addi.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_status = ST_NONE;
    if (r_stage.overflow) begin
      if (r_stage.opcode == OP_ADDI) begin
        w_status = ST_ADDI;
      end else if (r_stage.opcode == OP_RTYPE && r_stage.aluop == ALU_ADD) begin
        w_status = ST_ADD;
      end else if (r_stage.opcode == OP_RTYPE && r_stage.aluop == ALU_SUB) begin
        w_status = ST_SUB;
      end
    end
  end

  assign w_is_exc = (w_status != ST_NONE);

  // Select the destination and data by writing class. An exception redirects the write to r30.
  always_comb begin
    w_writes = 1'b0;
    w_dest   = '0;
    w_value  = '0;
    if (w_is_exc) begin
      w_writes = 1'b1;
      w_dest   = REG_STATUS;
      w_value  = {30'd0, w_status};
    end else begin
      case (r_stage.opcode)
        OP_RTYPE, OP_ADDI: begin
          w_writes = 1'b1;
          w_dest   = r_stage.rd;
          w_value  = r_stage.alu_result;
        end
        OP_LW: begin
          w_writes = 1'b1;
          w_dest   = r_stage.rd;
          w_value  = r_stage.mem_data;
        end
        OP_JAL: begin
          w_writes = 1'b1;
          w_dest   = REG_LINK;
          w_value  = r_stage.pc_plus1;
        end
        OP_SETX: begin
          w_writes = 1'b1;
          w_dest   = REG_STATUS;
          w_value  = r_stage.alu_result;
        end
        default: begin
          w_writes = 1'b0;
        end
      endcase
    end
  end

  // A valid entry commits in any cycle it is not stalled. r0 is never written.
  assign w_commit = r_valid & ~bus.stall;
  assign w_wb_en  = w_commit & w_writes & (w_dest != 5'd0);

  assign bus.wb_en       = w_wb_en;
  assign bus.wb_addr     = w_wb_en ? w_dest  : 5'd0;
  assign bus.wb_data     = w_wb_en ? w_value : 32'd0;
  assign bus.last_status = r_last_status;
  assign bus.ovf_count   = r_ovf_count;

  // Status tracking: mirror every r30 write and count overflow exceptions, saturating at 255.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last_status <= '0;
      r_ovf_count   <= '0;
    end else begin
      if (w_wb_en && w_dest == REG_STATUS) begin
        r_last_status <= w_value;
      end
      if (w_commit && w_is_exc && r_ovf_count != 8'hFF) begin
        r_ovf_count <= r_ovf_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mw_wb_stage.sv
// Testbench for mw_wb_stage. Directed scenarios and a randomized run are
// compared against a transaction-level model. The model holds one pending
// instruction and derives each writeback directly from the instruction-set
// rules for that instruction.
module tb_mw_wb_stage;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;

  typedef struct {
    logic [4:0]  opcode;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_plus1;
    logic        overflow;
  } ins_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mw_wb_stage_if bus ();

  mw_wb_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_valid;
  ins_t        m_ins;
  logic [31:0] m_last;
  int          m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] op, input logic [4:0] aluop, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                              input logic ovf);
    ins_t s;
    s.opcode = op; s.aluop = aluop; s.rd = rd;
    s.alu_result = alu; s.mem_data = mem; s.pc_plus1 = pc; s.overflow = ovf;
    return s;
  endfunction

  function automatic ins_t rnd_ins(input logic [4:0] op, input logic [4:0] aluop, input logic ovf);
    return mk(op, aluop, 5'($urandom_range(1, 29)), $urandom, $urandom, $urandom, ovf);
  endfunction

  // Architectural effect of committing instruction s: the register written
  // (-1 for none) and its value, plus whether it is an overflow exception.
  function automatic void predict(input ins_t s, output logic en, output logic [4:0] addr,
                                  output logic [31:0] data, output bit exc);
    int code;
    int dest;
    logic [31:0] val;
    code = 0;
    if (s.overflow) begin
      if (s.opcode == OP_ADDI) code = 2;
      else if (s.opcode == OP_R && s.aluop == 5'd0) code = 1;
      else if (s.opcode == OP_R && s.aluop == 5'd1) code = 3;
    end
    exc  = (code != 0);
    dest = -1;
    val  = 32'd0;
    if (exc) begin
      dest = 30;
      val  = code;
    end else if (s.opcode == OP_R || s.opcode == OP_ADDI) begin
      dest = s.rd;
      val  = s.alu_result;
    end else if (s.opcode == OP_LW) begin
      dest = s.rd;
      val  = s.mem_data;
    end else if (s.opcode == OP_JAL) begin
      dest = 31;
      val  = s.pc_plus1;
    end else if (s.opcode == OP_SETX) begin
      dest = 30;
      val  = s.alu_result;
    end
    en   = (dest > 0);
    addr = en ? dest[4:0] : 5'd0;
    data = en ? val : 32'd0;
  endfunction

  // One clock cycle: drive the inputs, check the outputs at the falling edge,
  // then advance the model across the rising edge.
  task automatic cycle(input logic st, input logic fl, input logic v, input ins_t s);
    logic        e_en;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    bit          e_exc;
    bus.stall         = st;
    bus.flush         = fl;
    bus.in_valid      = v;
    bus.in_opcode     = s.opcode;
    bus.in_aluop      = s.aluop;
    bus.in_rd         = s.rd;
    bus.in_alu_result = s.alu_result;
    bus.in_mem_data   = s.mem_data;
    bus.in_pc_plus1   = s.pc_plus1;
    bus.in_overflow   = s.overflow;
    @(negedge clock);
    predict(m_ins, e_en, e_a, e_d, e_exc);
    if (!(m_valid && !st)) begin
      e_en = 1'b0; e_a = 5'd0; e_d = 32'd0; e_exc = 1'b0;
    end
    check("wb_en", {31'd0, bus.wb_en}, {31'd0, e_en});
    check("wb_addr", {27'd0, bus.wb_addr}, {27'd0, e_a});
    check("wb_data", bus.wb_data, e_d);
    check("last_status", bus.last_status, m_last);
    check("ovf_count", {24'd0, bus.ovf_count}, m_ovf);
    @(posedge clock);
    if (!reset_n) begin
      m_valid = 1'b0;
      m_ins   = mk(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      m_last  = 32'd0;
      m_ovf   = 0;
    end else begin
      if (e_en && e_a == 5'd30) m_last = e_d;
      if (e_exc) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
      if (fl) m_valid = 1'b0;
      else if (!st) begin
        m_valid = v;
        m_ins   = s;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, rnd_ins(5'($urandom), 5'($urandom), 1'($urandom)));
  endtask

  initial begin
    ins_t s;
    ins_t nop;
    int   r;
    logic [4:0] ops [6];
    ops[0] = OP_R; ops[1] = OP_ADDI; ops[2] = OP_LW;
    ops[3] = OP_JAL; ops[4] = OP_SETX; ops[5] = 5'b11110;
    nop = mk(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Power-on reset, then compare against a cleared model.
    reset_n = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.in_opcode = '0; bus.in_aluop = '0; bus.in_rd = '0;
    bus.in_alu_result = '0; bus.in_mem_data = '0; bus.in_pc_plus1 = '0; bus.in_overflow = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    m_valid = 1'b0; m_ins = nop; m_last = 32'd0; m_ovf = 0;
    reset_n = 1'b1;
    idle();

    // add rd=5 result 7 without overflow
    cycle(1'b0, 1'b0, 1'b1, mk(OP_R, 5'd0, 5'd5, 32'd7, $urandom, $urandom, 1'b0));
    check("add_wb_en", {31'd0, bus.wb_en}, 32'd1);
    check("add_wb_addr", {27'd0, bus.wb_addr}, 32'd5);
    check("add_wb_data", bus.wb_data, 32'd7);
    idle();

    // sub with overflow, then addi with overflow
    cycle(1'b0, 1'b0, 1'b1, rnd_ins(OP_R, 5'd1, 1'b1));
    check("sub_exc_addr", {27'd0, bus.wb_addr}, 32'd30);
    check("sub_exc_data", bus.wb_data, 32'd3);
    idle();
    check("sub_last_status", bus.last_status, 32'd3);
    check("sub_ovf_count", {24'd0, bus.ovf_count}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, rnd_ins(OP_ADDI, 5'($urandom), 1'b1));
    check("addi_exc_data", bus.wb_data, 32'd2);
    idle();
    check("addi_ovf_count", {24'd0, bus.ovf_count}, 32'd2);

    // lw to r0 with a stray overflow flag, then jal
    cycle(1'b0, 1'b0, 1'b1, mk(OP_LW, 5'd0, 5'd0, $urandom, $urandom, $urandom, 1'b1));
    check("lw_r0_wb_en", {31'd0, bus.wb_en}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, mk(OP_JAL, 5'($urandom), 5'($urandom), $urandom, $urandom, 32'h40, 1'b0));
    check("lw_ovf_unchanged", {24'd0, bus.ovf_count}, 32'd2);
    idle();

    // add overflow held for three stalled cycles commits exactly once
    cycle(1'b0, 1'b0, 1'b1, rnd_ins(OP_R, 5'd0, 1'b1));
    repeat (3) cycle(1'b1, 1'b0, 1'b1, rnd_ins(OP_SETX, 5'd0, 1'b0));
    cycle(1'b0, 1'b0, 1'b0, nop);
    idle();
    check("stall_once_ovf", {24'd0, bus.ovf_count}, 32'd3);

    // stalled entry flushed at the same edge never commits
    cycle(1'b0, 1'b0, 1'b1, rnd_ins(OP_R, 5'd0, 1'b1));
    cycle(1'b1, 1'b1, 1'b1, rnd_ins(OP_R, 5'd0, 1'b1));
    idle();
    check("flush_stall_ovf", {24'd0, bus.ovf_count}, 32'd3);

    // setx writes its target to r30
    cycle(1'b0, 1'b0, 1'b1, mk(OP_SETX, 5'($urandom), 5'($urandom), 32'h1234, $urandom, $urandom, 1'b1));
    idle();
    check("setx_last_status", bus.last_status, 32'h1234);

    // 256 back-to-back overflows saturate the counter
    for (int i = 0; i < 256; i++) cycle(1'b0, 1'b0, 1'b1, rnd_ins(OP_R, 5'd0, 1'b1));
    idle();
    check("ovf_saturated", {24'd0, bus.ovf_count}, 32'd255);
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    check("rst_ovf_count", {24'd0, bus.ovf_count}, 32'd0);
    check("rst_last_status", bus.last_status, 32'd0);
    check("rst_wb_en", {31'd0, bus.wb_en}, 32'd0);

    // reset asserted while an overflow entry is stalled
    cycle(1'b0, 1'b0, 1'b1, rnd_ins(OP_ADDI, 5'd0, 1'b1));
    cycle(1'b1, 1'b0, 1'b0, nop);
    reset_n = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, nop);
    reset_n = 1'b1;
    idle();
    check("rst_stall_ovf", {24'd0, bus.ovf_count}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      s.opcode     = ops[$urandom_range(0, 5)];
      s.aluop      = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
      s.rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      s.alu_result = $urandom;
      s.mem_data   = $urandom;
      s.pc_plus1   = $urandom;
      s.overflow   = 1'($urandom);
      r = $urandom_range(0, 99);
      reset_n = (r < 2) ? 1'b0 : 1'b1;
      cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) != 0), s);
    end
    reset_n = 1'b1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mw_wb_stage.md
MW_WB_STAGE -- requirements
Module: mw_wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock.
REQ-004 stall  input  1  hold stage register and suppress commit.
REQ-005 flush  input  1  load a bubble into the stage register.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_opcode  input  5  instruction opcode.
REQ-008 in_aluop  input  5  ALU opcode (R-type only).
REQ-009 in_rd  input  5  destination register.
REQ-010 in_alu_result  input  32  ALU result, or the setx target T for setx.
REQ-011 in_mem_data  input  32  load data.
REQ-012 in_pc_plus1  input  32  PC+1 for jal.
REQ-013 in_overflow  input  1  ALU overflow flag.
REQ-014 wb_en  output  1  register-file write enable.
REQ-015 wb_addr  output  5  register-file write address.
REQ-016 wb_data  output  32  register-file write data.
REQ-017 last_status  output  32  last value committed to r30.
REQ-018 ovf_count  output  8  count of committed overflow exceptions.

Function
REQ-019 The stage register (valid, opcode, aluop, rd, alu_result, mem_data, pc_plus1, overflow) SHALL follow this per-edge priority: reset, then flush (valid<=0), then stall (hold), otherwise capture the inputs.
REQ-020 The block SHALL have 1-cycle latency: an instruction captured at edge N drives wb_* combinationally from the stage register during cycle N+1.
REQ-021 A commit SHALL occur in a cycle where stage valid=1 and stall=0; wb_en SHALL be 1 only on a commit that has a nonzero final wb_addr.
REQ-022 Writing classes: R-type 00000 and addi 00101 write alu_result to rd; lw 01000 writes mem_data to rd; jal 00011 writes pc_plus1 to r31; setx 10101 writes alu_result to r30; all other opcodes SHALL write nothing (wb_en=0).
REQ-023 The overflow exception SHALL apply only when stage overflow=1 and the instruction is R-type add (aluop 00000), R-type sub (aluop 00001), or addi; the overflow flag SHALL be ignored for all other instructions.
REQ-024 On an overflow exception, wb_addr SHALL be 30 and wb_data SHALL be the zero-extended status code: add=1, addi=2, sub=3.
REQ-025 A final wb_addr of 0 SHALL force wb_en=0; an overflow redirect to r30 is never suppressed.
REQ-026 When wb_en=0, wb_addr and wb_data SHALL be 0.
REQ-027 last_status SHALL load wb_data on every commit with wb_addr=30, covering both overflow exceptions and setx.
REQ-028 ovf_count SHALL increment on each overflow-exception commit and saturate at 255.
REQ-029 A stalled entry SHALL commit exactly once, in the first cycle with stall=0; the next input is captured at that same edge.
REQ-030 When flush and stall are both 1, flush SHALL win and the held entry SHALL be discarded without committing.

Reset
REQ-031 When reset_n=0 at an edge, the block SHALL clear stage valid and all stage fields, last_status and ovf_count to 0; wb_en, wb_addr and wb_data then read 0.
REQ-032 Reset asserted mid-stall SHALL discard the held entry with no commit and no counter change.

Verification
REQ-033 Scenario: add, rd=5, alu_result=7, overflow=0 -> next cycle wb_en=1, wb_addr=5, wb_data=7; ovf_count=0.
REQ-034 Scenario: R-type sub (aluop 00001), rd=4, overflow=1 -> wb_addr=30, wb_data=3; then last_status=3 and ovf_count=1; a repeat with addi -> wb_data=2, ovf_count=2.
REQ-035 Scenario: lw, rd=0, overflow=1 -> wb_en=0, ovf_count unchanged; jal with pc_plus1=0x40 -> wb_addr=31, wb_data=0x40.
REQ-036 Scenario: add with overflow held 3 cycles under stall -> exactly one commit and ovf_count +1; the same entry under stall with flush -> no commit.
REQ-037 Scenario: 256 back-to-back add overflows -> ovf_count=255 (saturated); then reset_n=0 for one edge -> ovf_count=0, last_status=0, wb_en=0.
REQ-038 Scenario: setx with T=0x1234 -> wb_addr=30, wb_data=0x1234, last_status=0x1234, ovf_count unchanged.
